trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller.sv | 113 +++++++++++
 tb/tb_trap_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller: saves mepc/mcause, fetches mtvec or mepc, and issues a one-cycle PC redirect.
// Optional TRAP_VECTORED_MODE_EN enables vectored interrupt targets when mtvec[1:0]=01.
module trap_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_req,
    input  logic [31:0] csr_read_data,
    input  logic        csr_ready,
    output logic [11:0] csr_read_address,
    output logic        csr_write_enable,
    output logic [11:0] csr_write_address,
    output logic [31:0] csr_write_data,
    output logic        trapped,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    typedef enum logic [2:0] {IDLE, WR_MEPC, WR_MCAUSE, RD_MTVEC, RD_MEPC, REDIRECT} state_t;
    state_t      state;
    logic [31:0] cause_q;
    logic        we_q;
    logic [11:0] waddr_q;
    logic [31:0] wdata_q;
    logic        rv_q;
    logic [31:0] rpc_q;
    logic [31:0] trap_target;
    logic        unused_ok;
    assign unused_ok = &{1'b0, trap_pc[1:0], csr_read_data[1:0]};
`ifdef TRAP_VECTORED_MODE_EN
    always_comb trap_target = (csr_read_data[1:0] == 2'b01 && cause_q[31])
        ? {csr_read_data[31:2], 2'b00} + {cause_q[29:0], 2'b00}
        : {csr_read_data[31:2], 2'b00};
`else
    always_comb trap_target = {csr_read_data[31:2], 2'b00};
`endif
    // Reset masks the strobes combinationally so an abort never leaks a write or redirect.
    assign csr_write_enable  = we_q & ~reset;
    assign csr_write_address = reset ? 12'h000 : waddr_q;
    assign csr_write_data    = reset ? 32'h0 : wdata_q;
    assign redirect_valid    = rv_q & ~reset;
    assign redirect_pc       = reset ? 32'h0 : rpc_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cause_q          <= '0;
            we_q             <= 1'b0;
            waddr_q          <= '0;
            wdata_q          <= '0;
            rv_q             <= 1'b0;
            rpc_q            <= '0;
            csr_read_address <= '0;
            trapped          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        state   <= WR_MEPC;
                        cause_q <= trap_cause;
                        we_q    <= 1'b1;
                        waddr_q <= 12'h341;
                        wdata_q <= {trap_pc[31:2], 2'b00};
                        trapped <= 1'b1;
                        busy    <= 1'b1;
                    end else if (mret_req) begin
                        state            <= RD_MEPC;
                        csr_read_address <= 12'h341;
                        busy             <= 1'b1;
                    end
                end
                WR_MEPC: begin
                    state   <= WR_MCAUSE;
                    waddr_q <= 12'h342;
                    wdata_q <= cause_q;
                end
                WR_MCAUSE: begin
                    state            <= RD_MTVEC;
                    we_q             <= 1'b0;
                    waddr_q          <= '0;
                    wdata_q          <= '0;
                    csr_read_address <= 12'h305;
                end
                RD_MTVEC: begin
                    if (csr_ready) begin
                        state            <= REDIRECT;
                        csr_read_address <= '0;
                        rv_q             <= 1'b1;
                        rpc_q            <= trap_target;
                    end
                end
                RD_MEPC: begin
                    if (csr_ready) begin
                        state            <= REDIRECT;
                        csr_read_address <= '0;
                        rv_q             <= 1'b1;
                        rpc_q            <= {csr_read_data[31:2], 2'b00};
                    end
                end
                REDIRECT: begin
                    state   <= IDLE;
                    rv_q    <= 1'b0;
                    rpc_q   <= '0;
                    trapped <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed vectors with hand-computed expectations for trap_controller.
module tb_trap_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trap_req = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_cause = '0;
    logic        mret_req = 1'b0;
    logic [31:0] csr_read_data = '0;
    logic        csr_ready = 1'b1;
    logic [11:0] csr_read_address;
    logic        csr_write_enable;
    logic [11:0] csr_write_address;
    logic [31:0] csr_write_data;
    logic        trapped;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    int          mcause_wr = 0;
    int          rv_count = 0;
    int          base;
    logic [31:0] vec_exp;

    trap_controller dut (
        .clk(clk), .reset(reset), .trap_req(trap_req), .trap_pc(trap_pc),
        .trap_cause(trap_cause), .mret_req(mret_req), .csr_read_data(csr_read_data),
        .csr_ready(csr_ready), .csr_read_address(csr_read_address),
        .csr_write_enable(csr_write_enable), .csr_write_address(csr_write_address),
        .csr_write_data(csr_write_data), .trapped(trapped), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (csr_write_enable) begin
            wr_count++;
            if (csr_write_address == 12'h342) mcause_wr++;
        end
        if (redirect_valid) rv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_trap(input logic [31:0] pc, input logic [31:0] cause);
        trap_pc = pc;
        trap_cause = cause;
        trap_req = 1'b1;
        tick();
        trap_req = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_trapped", {31'b0, trapped}, 0);
        check("rst_we", {31'b0, csr_write_enable}, 0);
        check("rst_raddr", {20'b0, csr_read_address}, 0);
        check("rst_rv", {31'b0, redirect_valid}, 0);
        reset = 1'b0;
        tick();
        check("idle_busy", {31'b0, busy}, 0);

        // direct trap
        csr_read_data = 32'h0000_3000;
        start_trap(32'h0000_4002, 32'h0000_000B);
        check("t1_we", {31'b0, csr_write_enable}, 1);
        check("t1_waddr", {20'b0, csr_write_address}, 32'h341);
        check("t1_wdata", csr_write_data, 32'h0000_4000);
        check("t1_trapped", {31'b0, trapped}, 1);
        check("t1_busy", {31'b0, busy}, 1);
        tick();
        check("t2_waddr", {20'b0, csr_write_address}, 32'h342);
        check("t2_wdata", csr_write_data, 32'h0000_000B);
        check("t2_trapped", {31'b0, trapped}, 1);
        tick();
        check("t3_we", {31'b0, csr_write_enable}, 0);
        check("t3_waddr", {20'b0, csr_write_address}, 0);
        check("t3_raddr", {20'b0, csr_read_address}, 32'h305);
        check("t3_trapped", {31'b0, trapped}, 1);
        tick();
        check("t4_rv", {31'b0, redirect_valid}, 1);
        check("t4_rpc", redirect_pc, 32'h0000_3000);
        check("t4_trapped", {31'b0, trapped}, 1);
        check("t4_raddr", {20'b0, csr_read_address}, 0);
        tick();
        check("t5_rv", {31'b0, redirect_valid}, 0);
        check("t5_busy", {31'b0, busy}, 0);
        check("t5_trapped", {31'b0, trapped}, 0);
        check("t_writes", wr_count, 2);

        // mret
        base = wr_count;
        csr_read_data = 32'h0000_4003;
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        check("m1_raddr", {20'b0, csr_read_address}, 32'h341);
        check("m1_busy", {31'b0, busy}, 1);
        check("m1_trapped", {31'b0, trapped}, 0);
        check("m1_we", {31'b0, csr_write_enable}, 0);
        tick();
        check("m2_rv", {31'b0, redirect_valid}, 1);
        check("m2_rpc", redirect_pc, 32'h0000_4000);
        check("m2_trapped", {31'b0, trapped}, 0);
        tick();
        check("m_writes", wr_count - base, 0);
        check("m3_rv", {31'b0, redirect_valid}, 0);

        // vectored interrupt
        csr_read_data = 32'h0000_3001;
`ifdef TRAP_VECTORED_MODE_EN
        vec_exp = 32'h0000_301C;
`else
        vec_exp = 32'h0000_3000;
`endif
        start_trap(32'h0000_1000, 32'h8000_0007);
        tick();
        tick();
        tick();
        check("v_rv", {31'b0, redirect_valid}, 1);
        check("v_rpc", redirect_pc, vec_exp);
        tick();

        // exception with mode 01 stays direct
        start_trap(32'h0000_1000, 32'h0000_0007);
        tick();
        tick();
        tick();
        check("vx_rpc", redirect_pc, 32'h0000_3000);
        tick();

        // csr_ready stall
        csr_read_data = 32'h0000_3000;
        csr_ready = 1'b0;
        start_trap(32'h0000_2000, 32'h0000_0002);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("s_raddr", {20'b0, csr_read_address}, 32'h305);
            check("s_rv", {31'b0, redirect_valid}, 0);
            tick();
        end
        check("s_hold", {20'b0, csr_read_address}, 32'h305);
        csr_ready = 1'b1;
        tick();
        check("s_rv_late", {31'b0, redirect_valid}, 1);
        check("s_rpc", redirect_pc, 32'h0000_3000);
        tick();

        // simultaneous requests and request while busy
        base = wr_count;
        trap_pc = 32'h0000_5000;
        trap_cause = 32'h0000_0003;
        trap_req = 1'b1;
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        check("b_waddr", {20'b0, csr_write_address}, 32'h341);
        check("b_trapped", {31'b0, trapped}, 1);
        tick();
        tick();
        tick();
        trap_req = 1'b0;
        check("b_rv", {31'b0, redirect_valid}, 1);
        tick();
        tick();
        check("b_busy", {31'b0, busy}, 0);
        check("b_writes", wr_count - base, 2);

        // reset during WR_MCAUSE
        base = mcause_wr;
        rv_count = 0;
        start_trap(32'h0000_6000, 32'h0000_0005);
        tick();
        reset = 1'b1;
        #1;
        check("r_we", {31'b0, csr_write_enable}, 0);
        tick();
        check("r_busy", {31'b0, busy}, 0);
        check("r_trapped", {31'b0, trapped}, 0);
        check("r_raddr", {20'b0, csr_read_address}, 0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("r_mcause_wr", mcause_wr - base, 0);
        check("r_no_redirect", rv_count, 0);
        check("r_idle", {31'b0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
